// File: rtl/lzd_normalize_arbiter.sv
// lzd_normalize_arbiter
// One leading-zero counter and left shifter shared by several requesters.
// A round-robin arbiter picks one request per cycle, and the chosen request is
// normalized combinationally. The result lands in a single output register.
//
// Handshake rule (both sides): a transfer happens on a rising edge where valid
// and ready are both high. Ready never waits for the same port's valid, apart
// from the arbitration itself. A source keeps its payload stable while
// valid && !ready.
module lzd_normalize_arbiter #(
  parameter int REQUESTERS = 2,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [REQUESTERS-1:0]                 req_valid,
  output logic [REQUESTERS-1:0]                 req_ready,
  input  logic [REQUESTERS-1:0][31:0]           req_value,
  input  logic [REQUESTERS-1:0][TAG_WIDTH-1:0]  req_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [31:0]                           out_value,
  output logic [4:0]                            out_zeros,
  output logic                                  out_zero,
  output logic [$clog2(REQUESTERS)-1:0]         out_src,
  output logic [TAG_WIDTH-1:0]                  out_tag
);

  localparam int SRC_W = $clog2(REQUESTERS);

  // Count leading zeros of a 32-bit word. An all-zero word reports 31, the
  // same count as 1. The out_zero flag tells those two cases apart.
  function automatic logic [4:0] lzc32(input logic [31:0] v);
    logic [4:0] z;
    z = 5'd31;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) z = 5'(31 - i);
    end
    return z;
  endfunction

  logic [SRC_W-1:0]     ptr_q, ptr_d;
  logic                 out_valid_q;
  logic [31:0]          out_value_q;
  logic [4:0]           out_zeros_q;
  logic                 out_zero_q;
  logic [SRC_W-1:0]     out_src_q;
  logic [TAG_WIDTH-1:0] out_tag_q;

  logic                 stage_free;
  logic                 grant_found;
  logic [SRC_W-1:0]     grant_idx;
  logic                 xfer;
  logic [31:0]          sel_value;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic [4:0]           sel_zeros;

  // The output stage can accept a new result when it is empty or is being drained.
  assign stage_free = !out_valid_q || out_ready;

  // Round-robin search: take the first valid requester at or after ptr, and wrap around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= REQUESTERS) idx = idx - REQUESTERS;
      if (!grant_found && req_valid[SRC_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(idx);
      end
    end
  end

  // Ready goes one-hot to the winner only when the stage is free and reset is released.
  always_comb begin
    req_ready = '0;
    if (reset_n && stage_free && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Select the winner's payload and normalize it so its leading one sits at bit 31.
  always_comb begin
    sel_value = req_value[grant_idx];
    sel_tag   = req_tag[grant_idx];
    sel_zeros = lzc32(sel_value);
  end

  // After a transfer the pointer moves to the requester just past the winner.
  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      if (grant_idx == SRC_W'(REQUESTERS - 1)) ptr_d = '0;
      else                                     ptr_d = grant_idx + SRC_W'(1);
    end
  end

  // Output register and arbitration pointer.
  // An output accept that comes with a new transfer reloads the register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_zeros_q <= '0;
      out_zero_q  <= 1'b0;
      out_src_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (xfer) begin
        out_valid_q <= 1'b1;
        out_value_q <= sel_value << sel_zeros;
        out_zeros_q <= sel_zeros;
        out_zero_q  <= (sel_value == 32'd0);
        out_src_q   <= grant_idx;
        out_tag_q   <= sel_tag;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_zeros = out_zeros_q;
  assign out_zero  = out_zero_q;
  assign out_src   = out_src_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_lzd_normalize_arbiter.sv
// tb_lzd_normalize_arbiter
// Directed vectors, hand-written corner sequences, and random traffic checked
// against an arithmetic reference model with an expected-result queue.
module tb_lzd_normalize_arbiter;

  localparam int R     = 2;
  localparam int TW    = 4;
  localparam int EXP_W = 1 + TW + 1 + 5 + 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [R-1:0]         req_valid;
  logic [R-1:0]         req_ready;
  logic [R-1:0][31:0]   req_value;
  logic [R-1:0][TW-1:0] req_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_value;
  logic [4:0]           out_zeros;
  logic                 out_zero;
  logic [0:0]           out_src;
  logic [TW-1:0]        out_tag;

  lzd_normalize_arbiter #(.REQUESTERS(R), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_value (req_value),
    .req_tag   (req_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_zeros (out_zeros),
    .out_zero  (out_zero),
    .out_src   (out_src),
    .out_tag   (out_tag)
  );

  int checks = 0;
  int errors = 0;

  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    int          src;
    logic [31:0] value;
    logic [3:0]  tag;
    logic [4:0]  exp_zeros;
    logic [31:0] exp_value;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Leading zeros come from the position of the most significant one (log2).
  function automatic int ref_zeros(input logic [31:0] v);
    longint msb;
    if (v == 32'd0) return 31;
    msb = longint'($clog2(longint'(v) + 64'd1)) - 1;
    return 31 - int'(msb);
  endfunction

  function automatic logic [EXP_W-1:0] ref_word(input int src, input logic [31:0] v,
                                                input logic [TW-1:0] tag);
    int           z;
    logic [63:0]  prod;
    z    = ref_zeros(v);
    prod = (64'(v) * (64'd1 << z)) & 64'hFFFF_FFFF;
    return {1'(src), tag, (v == 32'd0), 5'(z), prod[31:0]};
  endfunction

  function automatic logic [EXP_W-1:0] dut_word();
    return {out_src, out_tag, out_zero, out_zeros, out_value};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    req_valid = '0;
    req_value = '0;
    req_tag   = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [31:0] v, input logic [TW-1:0] t);
    req_valid[i] = 1'b1;
    req_value[i] = v;
    req_tag[i]   = t;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          m_ptr;
    bit          m_valid;
    logic [R-1:0] pend;
    logic [R-1:0] acc;
    logic [TW-1:0] seq [R];
    logic [31:0] held_val;
    int          n_rand;

    vecs[0] = '{0, 32'h0000_1234, 4'd5, 5'd19, 32'h91A0_0000, 1'b0};
    vecs[1] = '{1, 32'h0000_0000, 4'd1, 5'd31, 32'h0000_0000, 1'b1};
    vecs[2] = '{0, 32'h8000_0000, 4'd2, 5'd0,  32'h8000_0000, 1'b0};
    vecs[3] = '{1, 32'h0000_0001, 4'd3, 5'd31, 32'h8000_0000, 1'b0};
    vecs[4] = '{0, 32'hFFFF_FFFF, 4'd4, 5'd0,  32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1, 32'h0001_0000, 4'd6, 5'd15, 32'h8000_0000, 1'b0};
    vecs[6] = '{0, 32'h0000_0003, 4'd7, 5'd30, 32'hC000_0000, 1'b0};
    vecs[7] = '{1, 32'h4000_0000, 4'd8, 5'd1,  32'h8000_0000, 1'b0};
    vecs[8] = '{0, 32'h0F0F_0F0F, 4'd9, 5'd4,  32'hF0F0_F0F0, 1'b0};
    vecs[9] = '{1, 32'h00AB_CDEF, 4'hA, 5'd8,  32'hABCD_EF00, 1'b0};

    // Reset state: outputs cleared and no ready, even with requests pending.
    drive_idle();
    reset_n = 1'b0;
    set_req(0, 32'h1, 4'd1);
    set_req(1, 32'h2, 4'd2);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_out_data", 64'(dut_word()), 64'd0);
    drive_idle();
    do_reset();

    // Directed vectors, each from a single requester.
    for (int k = 0; k < 10; k++) begin
      set_req(vecs[k].src, vecs[k].value, vecs[k].tag);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", k), 64'(req_ready), 64'(1 << vecs[k].src));
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      chk($sformatf("vec%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_zeros", k), 64'(out_zeros), 64'(vecs[k].exp_zeros));
      chk($sformatf("vec%0d_value", k), 64'(out_value), 64'(vecs[k].exp_value));
      chk($sformatf("vec%0d_zero", k), 64'(out_zero), 64'(vecs[k].exp_zero));
      chk($sformatf("vec%0d_src", k), 64'(out_src), 64'(vecs[k].src));
      chk($sformatf("vec%0d_tag", k), 64'(out_tag), 64'(vecs[k].tag));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("drain_out_valid", 64'(out_valid), 64'd0);
    chk("drain_data_held", 64'(out_value), 64'hABCD_EF00);

    // Both requesters always valid: grants alternate, one result per cycle.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_req(0, 32'h0000_0100 + k, 4'(k));
      set_req(1, 32'h0010_0000 + k, 4'(8 + k));
      @(negedge clk);
      chk($sformatf("alt%0d_ready", k), 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k > 0) begin
        chk($sformatf("alt%0d_out_valid", k), 64'(out_valid), 64'd1);
        chk($sformatf("alt%0d_src", k), 64'(out_src), 64'((k - 1) % 2));
      end
      @(posedge clk); #1;
    end
    // Last grant was requester 0. Stall for 3 cycles with both requesters valid.
    out_ready = 1'b0;
    held_val  = out_value;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_ready", k), 64'(req_ready), 64'd0);
      chk($sformatf("stall%0d_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("stall%0d_src", k), 64'(out_src), 64'd0);
      chk($sformatf("stall%0d_value", k), 64'(out_value), 64'(held_val));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready", 64'(req_ready), 64'd2);
    @(posedge clk); #1;
    @(negedge clk);
    chk("unstall_src", 64'(out_src), 64'd1);

    // Reset during a stall: clears immediately, and requester 0 gets the first grant afterwards.
    @(posedge clk); #1;
    drive_idle();
    set_req(0, 32'h0000_00FF, 4'd3);
    @(posedge clk); #1;
    set_req(1, 32'h0000_0F00, 4'd4);
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    chk("pre_reset_ready", 64'(req_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(out_valid), 64'd0);
    chk("async_reset_data", 64'(dut_word()), 64'd0);
    chk("async_reset_ready", 64'(req_ready), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 64'(req_ready), 64'd1);

    // Random traffic checked against the reference model and the expected queue.
    drive_idle();
    do_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    pend    = '0;
    seq[0]  = '0;
    seq[1]  = '0;
    n_rand  = 600;
    for (int cyc = 0; cyc < n_rand; cyc++) begin
      for (int i = 0; i < R; i++) begin
        if (!pend[i]) begin
          req_valid[i] = (cyc < n_rand - 20) && ($urandom_range(0, 99) < 60);
          req_value[i] = $urandom >> $urandom_range(0, 32);
          req_tag[i]   = seq[i];
        end
      end
      out_ready = (cyc >= n_rand - 20) || ($urandom_range(0, 99) < 70);
      @(negedge clk);
      begin
        bit           free;
        int           g;
        logic [R-1:0] exp_rdy;
        chk("rand_out_valid", 64'(out_valid), 64'(m_valid));
        free = !m_valid || out_ready;
        g = -1;
        for (int i = 0; i < R; i++) begin
          int j;
          j = (m_ptr + i) % R;
          if (g < 0 && req_valid[j]) g = j;
        end
        exp_rdy = (free && g >= 0) ? R'(1 << g) : '0;
        chk("rand_req_ready", 64'(req_ready), 64'(exp_rdy));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("rand_unexpected_out", 64'd1, 64'd0);
          else chk("rand_out_word", 64'(dut_word()), 64'(exp_q.pop_front()));
        end
        acc = '0;
        if (exp_rdy != '0) begin
          exp_q.push_back(ref_word(g, req_value[g], req_tag[g]));
          acc[g]  = 1'b1;
          seq[g]  = seq[g] + 1'b1;
          m_ptr   = (g + 1) % R;
          m_valid = 1'b1;
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
      for (int i = 0; i < R; i++) pend[i] = req_valid[i] && !acc[i];
    end
    @(negedge clk);
    if (out_valid) begin
      if (exp_q.size() == 0) chk("final_unexpected_out", 64'd1, 64'd0);
      else chk("final_out_word", 64'(dut_word()), 64'(exp_q.pop_front()));
    end
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
